pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/mips_pkg.sv | 32 +++
 rtl/next_pc_sel.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared fetch-FSM state encoding, opcode constants and helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_blez  = 6'b000110;
  localparam logic [5:0] c_op_baln  = 6'b011011;

  // Word offset of a conditional branch: sign-extended immediate times four.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_sel.sv
// ============================================================================
// Module : next_pc_sel
// Brief  : Combinational next-PC selection (baln jump > taken branch > pc+4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_target,
  input  logic        i_branch,
  input  logic        i_br_cond,
  input  logic        i_baln,
  input  logic        i_baln_cond,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_seq;
  logic [31:0] w_btgt;
  logic [31:0] w_jtgt;
  logic [31:0] w_sel;

  assign w_seq  = i_pc + 32'd4;
  assign w_btgt = w_seq + branch_offset(i_target[15:0]);
  assign w_jtgt = {w_seq[31:28], i_target, 2'b00};

  always_comb begin
    w_sel = w_seq;
    if (i_baln && i_baln_cond) begin
      w_sel = w_jtgt;
    end else if (i_branch && i_br_cond) begin
      w_sel = w_btgt;
    end
  end

  assign o_next_pc = {w_sel[31:2], 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module : pc_fetch_unit
// Brief  : Instruction fetch FSM with pc/instr registers, ack timeout and
//          retired-instruction counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch,
  input  logic        br_cond,
  input  logic        baln,
  input  logic        baln_cond,
  output logic [31:0] pc,
  output logic [31:0] link_pc,
  output logic        fetch_fault,
  output logic [31:0] retired_cnt
);

  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_retired_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_fault;

  logic              w_capture;
  logic              w_retire_fire;
  logic              w_wait_clr;
  logic              w_wait_inc;
  logic              w_fault_set;
  logic [31:0]       w_next_pc;

  next_pc_sel u_next_pc_sel (
    .i_pc        (r_pc),
    .i_target    (r_instr[25:0]),
    .i_branch    (branch),
    .i_br_cond   (br_cond),
    .i_baln      (baln),
    .i_baln_cond (baln_cond),
    .o_next_pc   (w_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_retire_fire = 1'b0;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    w_fault_set   = 1'b0;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_wait_clr  = 1'b1;
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          // Counter reaches ACK_TIMEOUT on the same edge that enters FAULT.
          w_wait_inc = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_fault_set = 1'b1;
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (retire) begin
          w_retire_fire = 1'b1;
          w_wait_clr    = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_retired_cnt <= 32'd0;
      r_wait_cnt    <= '0;
      r_fault       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_retire_fire) begin
        r_pc          <= w_next_pc;
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign link_pc     = r_pc + 32'd4;
  assign fetch_fault = r_fault;
  assign retired_cnt = r_retired_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module : tb_pc_fetch_unit
// Brief  : Directed self-checking bench for pc_fetch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        retire;
  logic        branch;
  logic        br_cond;
  logic        baln;
  logic        baln_cond;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        fetch_fault;
  logic [31:0] retired_cnt;

  logic        ack_en;
  logic        ack_force;
  int          n_checks;
  int          n_fail;

  pc_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .retire      (retire),
    .branch      (branch),
    .br_cond     (br_cond),
    .baln        (baln),
    .baln_cond   (baln_cond),
    .pc          (pc),
    .link_pc     (link_pc),
    .fetch_fault (fetch_fault),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM: beq +4 at 0x0C, beq -2 at 0x10, baln 0x40 at 0x1000_0000.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_000C: rom = 32'h1000_0004;
      32'h0000_0010: rom = 32'h1000_FFFE;
      32'h1000_0000: rom = 32'h6C00_0040;
      default:       rom = 32'h8C00_0000 | a;
    endcase
  endfunction

  always_comb begin
    imem_ack   = (ack_en & imem_req) | ack_force;
    imem_rdata = ack_force ? 32'hDEAD_BEEF : rom(imem_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_req();
    for (int k = 0; k < 20 && !imem_req; k++) step();
    check_val("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_retire();
    retire = 1'b1;
    step();
    retire = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; retire = 1'b0; branch = 1'b0; br_cond = 1'b0;
    baln = 1'b0; baln_cond = 1'b0; ack_en = 1'b1; ack_force = 1'b0;
    step(); step();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check_val("rst_cnt", retired_cnt, 32'd0);

    // Sequential fetch 0, 4, 8 with one-cycle acks
    @(negedge clk); reset = 1'b0;
    #1 check_val("boot_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_for_req();
      check_val("seq_addr", imem_addr, 32'(4 * i));
      step();
      check_val("seq_valid", {31'd0, instr_valid}, 32'd1);
      check_val("seq_instr", instr, 32'h8C00_0000 | 32'(4 * i));
      do_retire();
    end
    check_val("seq_cnt", retired_cnt, 32'd3);

    // HOLD at 0x0C: stray ack ignored, retire=0 holds
    wait_for_req();
    check_val("addr_0c", imem_addr, 32'h0C);
    step();
    check_val("instr_0c", instr, 32'h1000_0004);
    ack_force = 1'b1;
    step(); step(); step();
    ack_force = 1'b0;
    check_val("hold_instr", instr, 32'h1000_0004);
    check_val("hold_pc", pc, 32'h0C);
    check_val("hold_valid", {31'd0, instr_valid}, 32'd1);

    // Branch not taken (br_cond=0) -> pc+4
    branch = 1'b1; br_cond = 1'b0;
    do_retire();
    branch = 1'b0;
    wait_for_req();
    check_val("ntaken_addr", imem_addr, 32'h10);
    step();
    check_val("beq_opcode", {26'd0, opcode}, {26'd0, c_op_beq});
    check_val("link_10", link_pc, 32'h14);

    // Taken branch, imm=0xFFFE: 0x14 - 8 = 0x0C
    branch = 1'b1; br_cond = 1'b1;
    do_retire();
    branch = 1'b0; br_cond = 1'b0;
    wait_for_req();
    check_val("taken_addr", imem_addr, 32'h0C);
    step();

    // Walk forward to HOLD at 0x20
    for (int i = 0; i < 10 && pc != 32'h20; i++) begin
      do_retire();
      wait_for_req();
      step();
    end
    check_val("pc_20", pc, 32'h20);
    check_val("cnt_10", retired_cnt, 32'd10);

    // Asynchronous reset in HOLD
    #2 reset = 1'b1;
    #1;
    check_val("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("arst_pc", pc, 32'h0);
    check_val("arst_cnt", retired_cnt, 32'd0);
    check_val("arst_instr", instr, 32'h0);
    @(negedge clk); reset = 1'b0;
    wait_for_req();
    check_val("arst_fetch", imem_addr, 32'h0);
    check_val("arst_cnt2", retired_cnt, 32'd0);

    // baln wins over branch, pc preloaded to 0x1000_0000
    reset = 1'b1;
    step();
    @(negedge clk); reset = 1'b0;
    force dut.r_pc = 32'h1000_0000;
    #1 release dut.r_pc;
    wait_for_req();
    check_val("baln_fetch", imem_addr, 32'h1000_0000);
    step();
    check_val("baln_opcode", {26'd0, opcode}, {26'd0, c_op_baln});
    check_val("baln_link", link_pc, 32'h1000_0004);
    baln = 1'b1; baln_cond = 1'b1; branch = 1'b1; br_cond = 1'b1;
    do_retire();
    baln = 1'b0; baln_cond = 1'b0; branch = 1'b0; br_cond = 1'b0;
    wait_for_req();
    check_val("baln_tgt", imem_addr, 32'h1000_0100);
    step();

    // retired_cnt wrap
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retired_cnt;
    check_val("cnt_preload", retired_cnt, 32'hFFFF_FFFF);
    ack_en = 1'b0;
    do_retire();
    check_val("cnt_wrap", retired_cnt, 32'd0);

    // Ack timeout: 15 missed cycles still REQ, 16th enters FAULT; retire ignored
    retire = 1'b1;
    repeat (15) step();
    check_val("to_req15", {31'd0, imem_req}, 32'd1);
    check_val("to_fault15", {31'd0, fetch_fault}, 32'd0);
    check_val("to_cnt15", retired_cnt, 32'd0);
    step();
    check_val("to_fault16", {31'd0, fetch_fault}, 32'd1);
    check_val("to_req16", {31'd0, imem_req}, 32'd0);
    ack_en = 1'b1;
    repeat (4) step();
    retire = 1'b0;
    check_val("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    check_val("fault_req", {31'd0, imem_req}, 32'd0);
    check_val("fault_valid", {31'd0, instr_valid}, 32'd0);
    check_val("fault_cnt", retired_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
